// File: rtl/ram_word_port_pkg.sv
// Shared types and constants for the word-over-byte RAM port A adapter.
// Lane byte order follows RAM_WORD_BIG_ENDIAN_EN (little-endian when undefined).
package ram_word_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [18:0] SELECTION_ADDR_DATA_ADDR = 19'h30E50;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT,
        RESP
    } state_e;

    // Bit position of byte lane 0..3 inside a 32-bit word
    function automatic logic [4:0] lane_lsb(input logic [1:0] lane);
`ifdef RAM_WORD_BIG_ENDIAN_EN
        return {~lane, 3'b000};
`else
        return {lane, 3'b000};
`endif
    endfunction

    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[lane_lsb(lane) +: 8];
    endfunction

endpackage

// File: rtl/ram_word_port_if.sv
// CPU-side word request/response bus of the RAM word adapter.
interface ram_word_port_if #(
    parameter int unsigned ADDR_W = 19
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );

endinterface

// File: rtl/ram_word_port_read_capture.sv
// Aligns RAM read data with the lane that requested it and assembles the word.
// word_c/last_c already include the byte arriving this cycle.
module ram_read_capture
    import ram_word_pkg::*;
#(
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [1:0]  issue_lane,
    input  logic [7:0]  ram_readdata,
    output logic        last_c,
    output logic [31:0] word_c
);

    logic [READ_LAT-1:0] vld_q;
    logic [1:0]          lane_q [READ_LAT];
    logic [31:0]         asm_q;
    logic                tap_vld;
    logic [1:0]          tap_lane;

    assign tap_vld  = vld_q[READ_LAT-1];
    assign tap_lane = lane_q[READ_LAT-1];

    // Delay line matching the RAM latency, plus the assembly register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int i = 0; i < int'(READ_LAT); i++) begin
                lane_q[i] <= 2'd0;
            end
            asm_q <= '0;
        end else begin
            vld_q[0]  <= issue_valid;
            lane_q[0] <= issue_lane;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                vld_q[i]  <= vld_q[i-1];
                lane_q[i] <= lane_q[i-1];
            end
            asm_q <= word_c;
        end
    end

    always_comb begin
        word_c = asm_q;
        if (tap_vld) begin
            word_c[lane_lsb(tap_lane) +: 8] = ram_readdata;
        end
    end

    assign last_c = tap_vld && (tap_lane == 2'd3);

endmodule

// File: rtl/ram_word_port.sv
// 32-bit word access adapter onto the 8-bit port A of the frame/data RAM.
// Byte order selected by RAM_WORD_BIG_ENDIAN_EN (see ram_word_pkg).
module ram_word_port
    import ram_word_pkg::*;
#(
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned DEPTH    = 524288,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    ram_word_port_if.slave    bus,
    output logic [ADDR_W-1:0] ram_address,
    output logic [7:0]        ram_writedata,
    output logic              ram_write_enable,
    input  logic [7:0]        ram_readdata
);

    localparam logic [ADDR_W:0] LAST_WORD_ADDR = (ADDR_W+1)'(DEPTH - WORD_BYTES);

    state_e            state_q, state_d;
    logic [1:0]        k_q, k_d, k_nxt;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [7:0]        ram_writedata_q, ram_writedata_d;
    logic              ram_we_q, ram_we_d;
    logic              accept_c;
    logic              out_of_range_c;
    logic              cap_last_c;
    logic [31:0]       cap_word_c;

    assign accept_c       = bus.req_valid && ready_q;
    assign out_of_range_c = {1'b0, bus.req_addr} > LAST_WORD_ADDR;

    assign bus.req_ready    = ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign ram_address      = ram_address_q;
    assign ram_writedata    = ram_writedata_q;
    assign ram_write_enable = ram_we_q;

    ram_read_capture #(
        .READ_LAT (READ_LAT)
    ) u_capture (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (state_q == READ),
        .issue_lane   (k_q),
        .ram_readdata (ram_readdata),
        .last_c       (cap_last_c),
        .word_c       (cap_word_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            k_q             <= 2'd0;
            addr_q          <= '0;
            wdata_q         <= '0;
            ready_q         <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_err_q       <= 1'b0;
            rsp_rdata_q     <= '0;
            ram_address_q   <= '0;
            ram_writedata_q <= '0;
            ram_we_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            k_q             <= k_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            ready_q         <= ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_err_q       <= rsp_err_d;
            rsp_rdata_q     <= rsp_rdata_d;
            ram_address_q   <= ram_address_d;
            ram_writedata_q <= ram_writedata_d;
            ram_we_q        <= ram_we_d;
        end
    end

    // Outputs are computed one cycle ahead so that every port is a flop
    always_comb begin
        state_d         = state_q;
        k_d             = k_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rsp_valid_d     = 1'b0;
        rsp_err_d       = 1'b0;
        rsp_rdata_d     = rsp_rdata_q;
        ram_address_d   = ram_address_q;
        ram_writedata_d = ram_writedata_q;
        ram_we_d        = 1'b0;
        k_nxt           = k_q + 2'd1;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    k_d     = 2'd0;
                    if (out_of_range_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        ram_address_d = bus.req_addr;
                        if (bus.req_write) begin
                            state_d         = WRITE;
                            ram_writedata_d = word_byte(bus.req_wdata, 2'd0);
                            ram_we_d        = 1'b1;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            WRITE: begin
                if (k_q == 2'd3) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    k_d             = k_nxt;
                    ram_address_d   = addr_q + ADDR_W'(k_nxt);
                    ram_writedata_d = word_byte(wdata_q, k_nxt);
                    ram_we_d        = 1'b1;
                end
            end
            READ: begin
                if (k_q == 2'd3) begin
                    state_d = WAIT;
                end else begin
                    k_d           = k_nxt;
                    ram_address_d = addr_q + ADDR_W'(k_nxt);
                end
            end
            WAIT: begin
                if (cap_last_c) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = cap_word_c;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

endmodule

// File: tb/tb_ram_word_port.sv
// Self-checking bench for ram_word_port: one instance with READ_LAT=1, one with READ_LAT=3,
// each on its own behavioural byte RAM; expectations come from a byte-array reference model.
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp); \
        end \
    end

module tb_ram_word_port;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DEPTH  = 524288;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              req_valid [2];
    logic              req_write [2];
    logic [ADDR_W-1:0] req_addr  [2];
    logic [31:0]       req_wdata [2];
    logic              req_ready [2];
    logic              rsp_valid [2];
    logic              rsp_err   [2];
    logic [31:0]       rsp_rdata [2];
    logic [ADDR_W-1:0] ram_addr  [2];
    logic [7:0]        ram_wdata [2];
    logic              ram_we    [2];
    logic [7:0]        ram_rdata [2];

    int errors = 0;
    int checks = 0;
    logic [31:0] last_rdata [2];

    ram_word_port_if #(.ADDR_W(ADDR_W)) bus0 ();
    ram_word_port_if #(.ADDR_W(ADDR_W)) bus1 ();

    assign bus0.req_valid = req_valid[0];
    assign bus0.req_write = req_write[0];
    assign bus0.req_addr  = req_addr[0];
    assign bus0.req_wdata = req_wdata[0];
    assign req_ready[0]   = bus0.req_ready;
    assign rsp_valid[0]   = bus0.rsp_valid;
    assign rsp_err[0]     = bus0.rsp_err;
    assign rsp_rdata[0]   = bus0.rsp_rdata;

    assign bus1.req_valid = req_valid[1];
    assign bus1.req_write = req_write[1];
    assign bus1.req_addr  = req_addr[1];
    assign bus1.req_wdata = req_wdata[1];
    assign req_ready[1]   = bus1.req_ready;
    assign rsp_valid[1]   = bus1.rsp_valid;
    assign rsp_err[1]     = bus1.rsp_err;
    assign rsp_rdata[1]   = bus1.rsp_rdata;

    ram_word_port #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(1)) dut0 (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus0),
        .ram_address      (ram_addr[0]),
        .ram_writedata    (ram_wdata[0]),
        .ram_write_enable (ram_we[0]),
        .ram_readdata     (ram_rdata[0])
    );

    ram_word_port #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(3)) dut1 (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus1),
        .ram_address      (ram_addr[1]),
        .ram_writedata    (ram_wdata[1]),
        .ram_write_enable (ram_we[1]),
        .ram_readdata     (ram_rdata[1])
    );

    // Behavioural RAMs (unwritten bytes read as zero)
    logic [7:0] mem0 [int];
    logic [7:0] mem1 [int];
    logic [7:0] rd0, rd1a, rd1b, rd1c;

    function automatic logic [7:0] ram_peek(input int u, input int a);
        if (u == 0) return mem0.exists(a) ? mem0[a] : 8'h00;
        return mem1.exists(a) ? mem1[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        rd0  <= ram_peek(0, int'(ram_addr[0]));
        rd1a <= ram_peek(1, int'(ram_addr[1]));
        rd1b <= rd1a;
        rd1c <= rd1b;
        if (ram_we[0] === 1'b1) mem0[int'(ram_addr[0])] = ram_wdata[0];
        if (ram_we[1] === 1'b1) mem1[int'(ram_addr[1])] = ram_wdata[1];
    end

    assign ram_rdata[0] = rd0;
    assign ram_rdata[1] = rd1c;

    // Reference model: expected RAM bytes per instance
    logic [7:0] ref_mem [int];

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] ref_peek(input int u, input int a);
        int key;
        key = u * int'(DEPTH) + a;
        return ref_mem.exists(key) ? ref_mem[key] : 8'h00;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input int k);
`ifdef RAM_WORD_BIG_ENDIAN_EN
        return 8'((w >> (24 - 8 * k)) & 32'hFF);
`else
        return 8'((w >> (8 * k)) & 32'hFF);
`endif
    endfunction

    function automatic logic [31:0] ref_word(input int u, input int a);
        logic [31:0] w;
        w = 32'h0;
        for (int k = 0; k < 4; k++) begin
`ifdef RAM_WORD_BIG_ENDIAN_EN
            w = w | (32'(ref_peek(u, a + k)) << (24 - 8 * k));
`else
            w = w | (32'(ref_peek(u, a + k)) << (8 * k));
`endif
        end
        return w;
    endfunction

    task automatic ref_write(input int u, input int a, input logic [31:0] w, input int nbytes);
        for (int k = 0; k < nbytes; k++) ref_mem[u * int'(DEPTH) + a + k] = lane_byte(w, k);
    endtask

    // Present a request and return #1 after the accepting edge (cycle T+1)
    task automatic issue(input int u, input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] w);
        int guard;
        guard = 0;
        req_write[u] = wr;
        req_addr[u]  = a;
        req_wdata[u] = w;
        req_valid[u] = 1'b1;
        while (req_ready[u] !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        `CHK("ready_wait", guard < 50, 1'b1)
        @(posedge clk); #1;
        req_valid[u] = 1'b0;
    endtask

    // Follow one accepted request to its response; returns in the response cycle
    task automatic observe(input int u, input logic wr, input logic rej, input logic [ADDR_W-1:0] a, input logic [31:0] w);
        int   exp_n, n_rsp, bad_we, bad_rdy, bad_mem;
        logic exp_we;
        n_rsp = 0; bad_we = 0; bad_rdy = 0; bad_mem = 0;
        exp_n = rej ? 1 : (wr ? 5 : 5 + lat_of(u));
        for (int n = 1; n <= 20; n++) begin
            exp_we = wr && !rej && (n <= 4);
            if (ram_we[u] !== exp_we) bad_we++;
            if (!rej && n <= 4 && ram_addr[u] !== a + ADDR_W'(n - 1)) bad_we++;
            if (exp_we && ram_wdata[u] !== lane_byte(w, n - 1)) bad_we++;
            if (req_ready[u] !== 1'b0) bad_rdy++;
            if (rsp_valid[u] === 1'b1) begin
                n_rsp = n;
                break;
            end
            @(posedge clk); #1;
        end
        `CHK("rsp_cycle", n_rsp, exp_n)
        `CHK("ram_port_seq", bad_we, 0)
        `CHK("ready_low", bad_rdy, 0)
        `CHK("rsp_err", rsp_err[u], rej)
        if (!wr && !rej) last_rdata[u] = ref_word(u, int'(a));
        `CHK("rsp_rdata", rsp_rdata[u], last_rdata[u])
        if (wr) begin
            for (int k = 0; k < 4; k++)
                if (ram_peek(u, int'(a) + k) !== ref_peek(u, int'(a) + k)) bad_mem++;
            `CHK("ram_bytes", bad_mem, 0)
        end
    endtask

    task automatic do_op(input int u, input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] w);
        logic rej;
        rej = int'(a) > int'(DEPTH) - 4;
        if (wr && !rej) ref_write(u, int'(a), w, 4);
        issue(u, wr, a, w);
        observe(u, wr, rej, a, w);
        @(posedge clk); #1;
        `CHK("rsp_pulse", rsp_valid[u], 1'b0)
        `CHK("ready_after", req_ready[u], 1'b1)
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]        exp0;
        logic              wr;
        int                u;
        logic [ADDR_W-1:0] a;

        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0;
            req_addr[i]  = '0;   req_wdata[i] = '0;
            last_rdata[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            `CHK("rst_ready", req_ready[i], 1'b0)
            `CHK("rst_rsp_valid", rsp_valid[i], 1'b0)
            `CHK("rst_rsp_err", rsp_err[i], 1'b0)
            `CHK("rst_rdata", rsp_rdata[i], 32'h0)
            `CHK("rst_ram_addr", ram_addr[i], 19'h0)
            `CHK("rst_ram_wdata", ram_wdata[i], 8'h0)
            `CHK("rst_ram_we", ram_we[i], 1'b0)
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        `CHK("ready_after_release0", req_ready[0], 1'b1)
        `CHK("ready_after_release1", req_ready[1], 1'b1)

        // Reset during a write: only the first two bytes land
        issue(0, 1'b1, 19'h0, 32'hA1B2C3D4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        `CHK("abort_we", ram_we[0], 1'b0)
        `CHK("abort_ready", req_ready[0], 1'b0)
        `CHK("abort_rsp", rsp_valid[0], 1'b0)
        ref_write(0, 0, 32'hA1B2C3D4, 2);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        `CHK("abort_ready_release", req_ready[0], 1'b1)
        `CHK("abort_no_rsp", rsp_valid[0], 1'b0)
        for (int k = 0; k < 4; k++) `CHK("abort_bytes", ram_peek(0, k), ref_peek(0, k))

        // Selection address word, both latencies
        do_op(0, 1'b1, 19'h30E50, 32'h0000_0064);
        do_op(0, 1'b0, 19'h30E50, 32'h0);
        do_op(1, 1'b1, 19'h30E50, 32'h0000_0064);
        do_op(1, 1'b0, 19'h30E50, 32'h0);

        // Range boundary
        do_op(0, 1'b1, 19'(DEPTH - 3), 32'hDEAD_BEEF);
        do_op(0, 1'b0, 19'(DEPTH - 4), 32'h0);
        do_op(1, 1'b0, 19'(DEPTH - 1), 32'h0);
        do_op(0, 1'b1, 19'(DEPTH - 4), 32'h1234_5678);
        do_op(0, 1'b0, 19'(DEPTH - 4), 32'h0);

        // Byte order of a known word
        do_op(0, 1'b1, 19'h100, 32'hA1B2C3D4);
`ifdef RAM_WORD_BIG_ENDIAN_EN
        exp0 = 8'hA1;
`else
        exp0 = 8'hD4;
`endif
        `CHK("byte_order_0x100", ram_peek(0, 32'h100), exp0)
        do_op(0, 1'b0, 19'h100, 32'h0);

        // req_valid held across two writes
        ref_write(0, 32'h200, 32'h1111_2222, 4);
        ref_write(0, 32'h300, 32'h3333_4444, 4);
        issue(0, 1'b1, 19'h200, 32'h1111_2222);
        req_addr[0] = 19'h300; req_wdata[0] = 32'h3333_4444; req_valid[0] = 1'b1;
        observe(0, 1'b1, 1'b0, 19'h200, 32'h1111_2222);
        @(posedge clk); #1;
        `CHK("b2b_ready_T6", req_ready[0], 1'b1)
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        observe(0, 1'b1, 1'b0, 19'h300, 32'h3333_4444);
        @(posedge clk); #1;
        `CHK("b2b_ready_after", req_ready[0], 1'b1)

        // Randomized mix over a small window plus occasional out-of-range
        for (int i = 0; i < 30; i++) begin
            u  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 19'(DEPTH - 4 + $urandom_range(1, 3));
            else a = 19'(32'h1000 + $urandom_range(0, 40));
            do_op(u, wr, a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
